// File: rtl/write_resp_channel_arb_pkg.sv
// Shared types for the write-response arbiter slice:
// BRESP codes, output-register states, slave count.
package write_resp_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NUM_SLAVES_SUPPORTED = 2;

  // SLVERR and DECERR both have bit 1 set.
  function automatic logic is_err(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/write_resp_channel_arb_if.sv
// B-channel bundle: two slave response ports in, one selected response out.
// slave modport = arbiter view, master modport = slave ports + decoder view.
interface write_resp_channel_arb_if #(
  parameter int Master_ID_Width = 1,
  parameter int Err_Count_Width = 8
);
  logic                       M00_AXI_bvalid;
  logic [Master_ID_Width-1:0] M00_AXI_bid;
  logic [1:0]                 M00_AXI_bresp;
  logic                       M00_AXI_bready;
  logic                       M01_AXI_bvalid;
  logic [Master_ID_Width-1:0] M01_AXI_bid;
  logic [1:0]                 M01_AXI_bresp;
  logic                       M01_AXI_bready;
  logic                       Sel_Valid;
  logic [Master_ID_Width-1:0] Sel_Resp_ID;
  logic [1:0]                 Sel_Write_Resp;
  logic                       Sel_Ready;
  logic [Err_Count_Width-1:0] Err_Count;

  modport slave (
    input  M00_AXI_bvalid, M00_AXI_bid, M00_AXI_bresp,
    output M00_AXI_bready,
    input  M01_AXI_bvalid, M01_AXI_bid, M01_AXI_bresp,
    output M01_AXI_bready,
    output Sel_Valid, Sel_Resp_ID, Sel_Write_Resp,
    input  Sel_Ready,
    output Err_Count
  );

  modport master (
    output M00_AXI_bvalid, M00_AXI_bid, M00_AXI_bresp,
    input  M00_AXI_bready,
    output M01_AXI_bvalid, M01_AXI_bid, M01_AXI_bresp,
    input  M01_AXI_bready,
    input  Sel_Valid, Sel_Resp_ID, Sel_Write_Resp,
    output Sel_Ready,
    input  Err_Count
  );
endinterface

// File: rtl/write_resp_channel_arb_rr_arb.sv
// 2-request round-robin arbiter; owns the priority pointer.
// Ports: clk, rst (sync high), req[1:0], advance, grant[1:0] onehot.
module wresp_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr = index of the slave holding priority
  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    if (!ptr_q) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  // Priority moves to the slave after the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (|grant))
      ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/write_resp_channel_arb.sv
// Round-robin B-channel collector with a one-entry output register.
// Ports: ACLK, ARESET (sync high), bus (slave modport) with slave B ports, Sel_* and Err_Count.
module write_resp_channel_arb
  import write_resp_pkg::*;
#(
  parameter int Num_Of_Slaves   = 2,
  parameter int Master_ID_Width = 1,
  parameter int Err_Count_Width = 8
) (
  input logic                      ACLK,
  input logic                      ARESET,
  write_resp_channel_arb_if.slave  bus
);

  logic [Num_Of_Slaves-1:0]   req;
  logic [Num_Of_Slaves-1:0]   grant;
  logic                       hs;
  logic                       load;
  state_t                     state_q, state_d;
  logic [Master_ID_Width-1:0] id_q, id_d;
  logic [1:0]                 resp_q, resp_d;
  logic [Err_Count_Width-1:0] err_q, err_d;

  // A held response that is being accepted frees the
  // register for a same-cycle reload.
  always_comb begin
    req  = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};
    hs   = (state_q == FULL) && bus.Sel_Ready;
    load = !ARESET && (|req)
        && ((state_q == EMPTY) || hs);
  end

  wresp_rr_arb u_arb (
    .clk     (ACLK),
    .rst     (ARESET),
    .req     (req),
    .advance (load),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    resp_d  = resp_q;
    err_d   = err_q;
    if (hs && is_err(resp_q) && (err_q != '1))
      err_d = err_q + 1'b1;
    if (load) begin
      state_d = FULL;
      if (grant[1]) begin
        id_d   = bus.M01_AXI_bid;
        resp_d = bus.M01_AXI_bresp;
      end else begin
        id_d   = bus.M00_AXI_bid;
        resp_d = bus.M00_AXI_bresp;
      end
    end else if (hs) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= EMPTY;
      id_q    <= '0;
      resp_q  <= 2'b00;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign bus.M00_AXI_bready = load & grant[0];
  assign bus.M01_AXI_bready = load & grant[1];
  assign bus.Sel_Valid      = (state_q == FULL);
  assign bus.Sel_Resp_ID    = id_q;
  assign bus.Sel_Write_Resp = resp_q;
  assign bus.Err_Count      = err_q;

endmodule

// File: doc/write_resp_channel_arb.md
# write_resp_channel_arb

Slave-side counterpart of the write-response decoder: collects B-channel responses from the slave ports, arbitrates among them round-robin, and presents a single registered response (master ID, BRESP, valid) to the write-response decoder, which routes it to the owning master. Holds each response until the addressed master accepts it. Pops exactly one beat per slave handshake, and counts error responses forwarded.

## Interface
- Num_Of_Slaves, 2, number of slave B ports; fixed at 2 in this revision.
- Master_ID_Width, 1, width of BID and Sel_Resp_ID.
- Err_Count_Width, 8, width of the saturating error counter.

- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  reset, synchronous, active-high.
- M00_AXI_bvalid  in  1  slave 0 response valid.
- M00_AXI_bid  in  Master_ID_Width  slave 0 response ID, i.e. the destination master.
- M00_AXI_bresp  in  2  slave 0 response code.
- M00_AXI_bready  out  1  accept to slave 0.
- M01_AXI_bvalid / M01_AXI_bid / M01_AXI_bresp / M01_AXI_bready: same as M00, for slave 1.
- Sel_Valid  out  1  registered response valid to the decoder.
- Sel_Resp_ID  out  Master_ID_Width  registered destination master ID.
- Sel_Write_Resp  out  2  registered BRESP.
- Sel_Ready  in  1  bready of the addressed master, muxed back by the decoder.
- Err_Count  out  Err_Count_Width  count of SLVERR/DECERR responses delivered.

## Operation
- The block is a one-entry output register (states EMPTY and FULL) driven by a 2-way round-robin arbiter.
- load = !ARESET && any bvalid && (state==EMPTY || (Sel_Valid && Sel_Ready)).
- grant selection: the requesting slave with highest priority. The priority pointer points to the slave after the last granted slave. After reset, slave 0 has priority.
- Mxx_AXI_bready = load && grant==xx. This is combinational from bvalid, which AXI permits. At most one bready is high per cycle.
- On load:
  - capture the granted bid and bresp into Sel_Resp_ID and Sel_Write_Resp.
  - Sel_Valid goes to 1; state becomes FULL.
  - the pointer advances past the granted slave.
- FULL with Sel_Ready=0: all Sel_* outputs hold stable and both bready outputs stay 0.
- FULL with Sel_Ready=1:
  - if no bvalid, return to EMPTY and drop Sel_Valid next cycle.
  - if any bvalid, reload in the same cycle (back-to-back, no bubble).
- Err_Count increments by 1 on each output handshake (Sel_Valid && Sel_Ready) whose Sel_Write_Resp[1]==1. It saturates at all-ones. OKAY and EXOKAY do not count.
- Both slaves valid continuously: grants alternate 0,1,0,1…
- Only one slave valid: that slave is granted every opportunity; the pointer still advances.

## Timing
- Reset values: Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=0, Err_Count=0, state=EMPTY, pointer→slave 0, M00/M01_AXI_bready=0.
- Latency: a slave bvalid accepted at edge N gives Sel_Valid=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 response per cycle while Sel_Ready stays high.
- Reset asserted mid-operation: on the next edge Sel_Valid goes to 0 and the held response is discarded. No bready is issued while ARESET=1.
- Sel_Valid never deasserts without a handshake, except by reset.
- Sel_Resp_ID and Sel_Write_Resp never change while Sel_Valid=1 and Sel_Ready=0.
- Err_Count updates at the edge of the handshake; the new value is visible the following cycle.

## Structure
- Shared package write_resp_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - state_t enum: EMPTY, FULL.
  - localparam NUM_SLAVES_SUPPORTED=2.
- Sub-module wresp_rr_arb: 2-request round-robin arbiter with inputs req[1:0] and advance, output grant onehot. It owns the priority pointer.
- The top level contains the output register, the load/bready logic and the error counter.

## Test plan
- Reset: hold ARESET 3 cycles with both bvalid=1 → both bready stay 0, Sel_Valid=0, Err_Count=0 throughout.
- Single route: M01 bvalid=1, bid=1, bresp=2'b01 with Sel_Ready=1 → M01_AXI_bready pulses one cycle; the next cycle gives Sel_Valid=1, Sel_Resp_ID=1, Sel_Write_Resp=2'b01; Err_Count stays 0.
- Backpressure: load M00 (bid=0, bresp=2'b10), hold Sel_Ready=0 for 5 cycles → outputs stable and both bready stay 0. Raise Sel_Ready → handshake, and Err_Count=1 the next cycle.
- Fairness: both slaves valid for 6 beats with Sel_Ready=1 → grants go 0,1,0,1,0,1 and Sel_Valid stays high every cycle after the first.
- Saturation: deliver 260 DECERR responses → Err_Count reads 255 and holds.
- Mid-operation reset: with FULL and Sel_Ready=0, assert ARESET one cycle → Sel_Valid=0 the next cycle, and the next grant goes to slave 0.
